// File: rtl/board_pkg.sv
// Shared types and geometry for the playfield memory arbiter.
// Cell colour type, arbiter state, read-owner tags and a bounds helper.
package board_pkg;

    localparam int COLS   = 10;
    localparam int ROWS   = 20;
    localparam int CELL_W = 3;
    localparam int ADDR_W = 8;
    localparam int CELLS  = COLS * ROWS;

    typedef logic [CELL_W-1:0] cell_t;
    typedef logic [ADDR_W-1:0] addr_t;

    localparam cell_t EMPTY = '0;

    typedef enum logic {
        SERVE,
        CLEAR
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_DISP,
        OWN_GAME
    } owner_t;

    function automatic logic in_board(input addr_t a);
        return a < addr_t'(CELLS);
    endfunction

endpackage

// File: rtl/board_mem_arbiter_if.sv
// Bus bundle between the arbiter, its three users and the board RAM.
// slave: arbiter view. master: the users + RAM side.
interface board_mem_arbiter_if;
    import board_pkg::*;

    logic  disp_re;
    addr_t disp_addr;
    cell_t disp_rdata;
    logic  disp_rvalid;

    logic  game_req;
    logic  game_we;
    addr_t game_addr;
    cell_t game_wdata;
    logic  game_ack;
    cell_t game_rdata;

    logic  clr_start;
    logic  clr_busy;

    logic  mem_en;
    logic  mem_we;
    addr_t mem_addr;
    cell_t mem_wdata;
    cell_t mem_rdata;

    modport slave (
        input  disp_re, disp_addr,
        input  game_req, game_we,
        input  game_addr, game_wdata,
        input  clr_start, mem_rdata,
        output disp_rdata, disp_rvalid,
        output game_ack, game_rdata,
        output clr_busy,
        output mem_en, mem_we,
        output mem_addr, mem_wdata
    );

    modport master (
        output disp_re, disp_addr,
        output game_req, game_we,
        output game_addr, game_wdata,
        output clr_start, mem_rdata,
        input  disp_rdata, disp_rvalid,
        input  game_ack, game_rdata,
        input  clr_busy,
        input  mem_en, mem_we,
        input  mem_addr, mem_wdata
    );

endinterface

// File: rtl/board_rd_pipe.sv
// Two-stage owner pipeline routing RAM read data back to its requester.
// Ports: i_owner/i_zero (issue cycle), i_mem_rdata, o_disp_*, o_game_*.
module board_rd_pipe
    import board_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  owner_t i_owner,
    input  logic   i_zero,
    input  cell_t  i_mem_rdata,
    output logic   o_disp_rvalid,
    output cell_t  o_disp_rdata,
    output logic   o_game_ack,
    output cell_t  o_game_rdata
);

    owner_t r_owner;
    logic   r_zero;
    logic   r_disp_v;
    cell_t  r_disp_d;
    logic   r_game_v;
    cell_t  r_game_d;

    logic   w_disp;
    logic   w_game;

    assign w_disp = (r_owner == OWN_DISP);
    assign w_game = (r_owner == OWN_GAME);

    // Stage 1 holds the tag while RAM produces data;
    // stage 2 captures it. Writes/trapped accesses return 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner  <= OWN_NONE;
            r_zero   <= 1'b0;
            r_disp_v <= 1'b0;
            r_disp_d <= EMPTY;
            r_game_v <= 1'b0;
            r_game_d <= EMPTY;
        end else begin
            r_owner  <= i_owner;
            r_zero   <= i_zero;
            r_disp_v <= w_disp;
            r_disp_d <= (w_disp && !r_zero) ?
                        i_mem_rdata : EMPTY;
            r_game_v <= w_game;
            r_game_d <= (w_game && !r_zero) ?
                        i_mem_rdata : EMPTY;
        end
    end

    assign o_disp_rvalid = r_disp_v;
    assign o_disp_rdata  = r_disp_d;
    assign o_game_ack    = r_game_v;
    assign o_game_rdata  = r_game_d;

endmodule

// File: rtl/board_mem_arbiter.sv
// Single-port playfield RAM arbiter: display > clear sweep > game.
// Ports: clk, rst, bus (slave); oob_err only with BOARD_ARB_BOUNDS_EN.
module board_mem_arbiter
    import board_pkg::*;
(
    input  logic clk,
    input  logic rst,
    board_mem_arbiter_if.slave bus
`ifdef BOARD_ARB_BOUNDS_EN
    ,
    output logic oob_err
`endif
);

    arb_state_t r_state;
    arb_state_t w_state_nx;
    addr_t      r_cnt;
    addr_t      w_cnt_nx;
    logic       r_inflight;

    logic       w_disp_ok;
    logic       w_game_ok;
    logic       w_grant;
    logic       w_clr_wr;
    logic       w_game_ack;
    owner_t     w_owner;
    logic       w_zero;

`ifdef BOARD_ARB_BOUNDS_EN
    logic r_oob;

    assign w_disp_ok = in_board(bus.disp_addr);
    assign w_game_ok = in_board(bus.game_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_oob <= 1'b0;
        else if ((bus.disp_re && !w_disp_ok) ||
                 (w_grant && !w_game_ok))
            r_oob <= 1'b1;
    end

    assign oob_err = r_oob;
`else
    assign w_disp_ok = 1'b1;
    assign w_game_ok = 1'b1;
`endif

    // In-flight flag keeps a held req from a second grant
    // until the ack cycle has passed.
    assign w_grant = (r_state == SERVE) && !bus.disp_re &&
                     bus.game_req && !r_inflight;
    assign w_clr_wr = (r_state == CLEAR) && !bus.disp_re;

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        unique case (r_state)
            SERVE: begin
                if (bus.clr_start)
                    w_state_nx = CLEAR;
            end
            CLEAR: begin
                if (w_clr_wr) begin
                    if (r_cnt == addr_t'(CELLS - 1)) begin
                        w_cnt_nx   = '0;
                        w_state_nx = SERVE;
                    end else begin
                        w_cnt_nx = r_cnt + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = EMPTY;
        w_owner       = OWN_NONE;
        w_zero        = 1'b0;
        unique case (1'b1)
            bus.disp_re: begin
                bus.mem_en   = w_disp_ok;
                bus.mem_addr = bus.disp_addr;
                w_owner      = OWN_DISP;
                w_zero       = !w_disp_ok;
            end
            w_clr_wr: begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = r_cnt;
                bus.mem_wdata = EMPTY;
            end
            w_grant: begin
                bus.mem_en    = w_game_ok;
                bus.mem_we    = bus.game_we && w_game_ok;
                bus.mem_addr  = bus.game_addr;
                bus.mem_wdata = bus.game_we ?
                                bus.game_wdata : EMPTY;
                w_owner       = OWN_GAME;
                w_zero        = bus.game_we || !w_game_ok;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= SERVE;
            r_cnt      <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            if (w_grant)
                r_inflight <= 1'b1;
            else if (w_game_ack)
                r_inflight <= 1'b0;
        end
    end

    board_rd_pipe u_pipe (
        .clk           (clk),
        .rst           (rst),
        .i_owner       (w_owner),
        .i_zero        (w_zero),
        .i_mem_rdata   (bus.mem_rdata),
        .o_disp_rvalid (bus.disp_rvalid),
        .o_disp_rdata  (bus.disp_rdata),
        .o_game_ack    (w_game_ack),
        .o_game_rdata  (bus.game_rdata)
    );

    assign bus.game_ack = w_game_ack;
    assign bus.clr_busy = (r_state == CLEAR);

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Randomised bench for board_mem_arbiter against a cycle-indexed model.
// Define BOARD_ARB_BOUNDS_EN to exercise the out-of-range trap.
module tb_board_mem_arbiter;
    import board_pkg::*;

    logic clk = 1'b0;
    logic rst;

    board_mem_arbiter_if bus();

`ifdef BOARD_ARB_BOUNDS_EN
    logic oob_err;
`endif

    board_mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef BOARD_ARB_BOUNDS_EN
        ,
        .oob_err (oob_err)
`endif
    );

    always #5 clk = ~clk;

    cell_t ram [256];

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we)
                ram[bus.mem_addr] <= bus.mem_wdata;
            else
                bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    cell_t ref_mem [256];
    logic  m_clr;
    int    m_cnt;
    int    m_next;
    logic  m_oob;
    logic  exp_dv [4];
    cell_t exp_dd [4];
    logic  exp_ga [4];
    cell_t exp_gd [4];

    logic  g_act;
    logic  g_granted;
    logic  g_we;
    addr_t g_addr;
    cell_t g_wd;
    logic  nx_we;
    addr_t nx_addr;
    cell_t nx_wd;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d",
                     tag, got, exp, cyc);
        end
    endtask

    function automatic logic bad(input addr_t a);
`ifdef BOARD_ARB_BOUNDS_EN
        return int'(a) >= CELLS;
`else
        return 1'b0;
`endif
    endfunction

    function automatic addr_t rnd_addr(input logic allow_oob);
`ifdef BOARD_ARB_BOUNDS_EN
        if (allow_oob && ($urandom % 8 == 0))
            return addr_t'(CELLS + $urandom % (256 - CELLS));
`endif
        if (allow_oob) ;
        return addr_t'($urandom % CELLS);
    endfunction

    task automatic model_clear();
        m_clr  = 1'b0;
        m_cnt  = 0;
        m_next = 0;
        m_oob  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_dv[i] = 1'b0;
            exp_ga[i] = 1'b0;
            exp_dd[i] = EMPTY;
            exp_gd[i] = EMPTY;
        end
    endtask

    task automatic idle_inputs();
        bus.disp_re    = 1'b0;
        bus.disp_addr  = '0;
        bus.game_req   = 1'b0;
        bus.game_we    = 1'b0;
        bus.game_addr  = '0;
        bus.game_wdata = EMPTY;
        bus.clr_start  = 1'b0;
        g_act          = 1'b0;
        g_granted      = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        #1;
        chk("rst_busy", 32'(bus.clr_busy), 0);
        chk("rst_dv", 32'(bus.disp_rvalid), 0);
        chk("rst_dd", 32'(bus.disp_rdata), 0);
        chk("rst_ack", 32'(bus.game_ack), 0);
        chk("rst_gd", 32'(bus.game_rdata), 0);
        chk("rst_men", 32'(bus.mem_en), 0);
`ifdef BOARD_ARB_BOUNDS_EN
        chk("rst_oob", 32'(oob_err), 0);
`endif
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic step(input logic dre, input addr_t daddr,
                        input logic cst, input logic want);
        int s;
        int n;
        logic clr0;
        logic oob;
        logic [12:0] e_mem;
        logic [12:0] g_mem;
        @(negedge clk);
        s = cyc % 4;
        chk("disp_rvalid", 32'(bus.disp_rvalid), 32'(exp_dv[s]));
        if (exp_dv[s])
            chk("disp_rdata", 32'(bus.disp_rdata), 32'(exp_dd[s]));
        chk("game_ack", 32'(bus.game_ack), 32'(exp_ga[s]));
        if (exp_ga[s]) begin
            chk("game_rdata", 32'(bus.game_rdata), 32'(exp_gd[s]));
            g_act = 1'b0;
        end
        chk("clr_busy", 32'(bus.clr_busy), 32'(m_clr));
`ifdef BOARD_ARB_BOUNDS_EN
        chk("oob_err", 32'(oob_err), 32'(m_oob));
`endif
        exp_dv[s] = 1'b0;
        exp_ga[s] = 1'b0;
        if (want && !g_act) begin
            g_act     = 1'b1;
            g_granted = 1'b0;
            g_we      = nx_we;
            g_addr    = nx_addr;
            g_wd      = nx_wd;
        end
        bus.disp_re    = dre;
        bus.disp_addr  = daddr;
        bus.clr_start  = cst;
        bus.game_req   = g_act;
        bus.game_we    = g_we;
        bus.game_addr  = g_addr;
        bus.game_wdata = g_wd;
        #1;
        n     = (cyc + 2) % 4;
        clr0  = m_clr;
        e_mem = '0;
        if (dre) begin
            oob = bad(daddr);
            if (!oob)
                e_mem = {2'b10, daddr, 3'b000};
            else
                m_oob = 1'b1;
            exp_dv[n] = 1'b1;
            exp_dd[n] = oob ? EMPTY : ref_mem[daddr];
        end else if (clr0) begin
            e_mem = {2'b11, 8'(m_cnt), 3'b000};
            ref_mem[m_cnt] = EMPTY;
            m_cnt++;
            if (m_cnt == CELLS) begin
                m_cnt = 0;
                m_clr = 1'b0;
            end
        end else if (g_act && !g_granted && cyc >= m_next) begin
            g_granted = 1'b1;
            m_next    = cyc + 3;
            oob       = bad(g_addr);
            if (!oob)
                e_mem = {1'b1, g_we, g_addr,
                         g_we ? g_wd : EMPTY};
            else
                m_oob = 1'b1;
            exp_ga[n] = 1'b1;
            exp_gd[n] = (g_we || oob) ? EMPTY : ref_mem[g_addr];
            if (g_we && !oob)
                ref_mem[g_addr] = g_wd;
        end
        if (!clr0 && cst)
            m_clr = 1'b1;
        g_mem = {bus.mem_en, bus.mem_we,
                 bus.mem_en ? bus.mem_addr : addr_t'(0),
                 bus.mem_we ? bus.mem_wdata : EMPTY};
        chk("mem_access", 32'(g_mem), 32'(e_mem));
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic set_nx(input logic we, input addr_t a,
                          input cell_t d);
        nx_we   = we;
        nx_addr = a;
        nx_wd   = d;
    endtask

    task automatic fill(input cell_t v);
        for (int i = 0; i < 256; i++) begin
            ram[i]     = v;
            ref_mem[i] = v;
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        set_nx(1'b0, '0, EMPTY);
        model_clear();
        for (int i = 0; i < 256; i++) begin
            ram[i]     = cell_t'($urandom);
            ref_mem[i] = ram[i];
        end
        ram[5]     = 3'd3;
        ref_mem[5] = 3'd3;
        do_reset();

        repeat (10) step(1'b1, 8'd5, 1'b0, 1'b0);
        idle(3);

        set_nx(1'b1, 8'd12, 3'd6);
        step(1'b0, '0, 1'b0, 1'b1);
        idle(4);
        set_nx(1'b0, 8'd12, EMPTY);
        step(1'b0, '0, 1'b0, 1'b1);
        idle(4);

        set_nx(1'b0, 8'd30, EMPTY);
        step(1'b1, rnd_addr(1'b0), 1'b0, 1'b1);
        repeat (6) step(1'b1, rnd_addr(1'b0), 1'b0, 1'b0);
        idle(5);

        fill(3'd7);
        step(1'b0, '0, 1'b1, 1'b0);
        idle(5);
        set_nx(1'b0, 8'd3, EMPTY);
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        idle(205);
        for (int a = 0; a < CELLS; a++)
            step(1'b1, addr_t'(a), 1'b0, 1'b0);
        idle(4);

        fill(3'd7);
        step(1'b0, '0, 1'b1, 1'b0);
        for (int k = 0; k < 420; k++)
            step(k % 2 == 0, rnd_addr(1'b0), 1'b0, 1'b0);
        idle(4);

        step(1'b0, '0, 1'b1, 1'b0);
        for (int k = 0; k < 50; k++)
            step(k % 2 == 0, rnd_addr(1'b0), 1'b0, 1'b0);
        do_reset();
        idle(10);
        for (int a = 0; a < CELLS; a += 7)
            step(1'b1, addr_t'(a), 1'b0, 1'b0);
        idle(4);

`ifdef BOARD_ARB_BOUNDS_EN
        set_nx(1'b1, 8'd200, 3'd5);
        step(1'b0, '0, 1'b0, 1'b1);
        idle(10);
        step(1'b1, 8'd250, 1'b0, 1'b0);
        idle(4);
        do_reset();
        idle(3);
`endif

        for (int k = 0; k < 3000; k++) begin
            set_nx(1'(($urandom % 2)), rnd_addr(1'b1),
                   cell_t'($urandom));
            step(($urandom % 3) == 0, rnd_addr(1'b1),
                 ($urandom % 300) == 0, 1'(($urandom % 2)));
        end
        idle(6);

        $display("TB_RESULT checks=%0d failures=%0d",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/board_mem_arbiter.md
Name: board_mem_arbiter

Overview:
- Arbitrates single-port playfield memory (10x20 cells, 3-bit colour/cell) between three users: VGA renderer read port, game-logic read/write port, internal board-clear sweeper.
- Sits between game FSM, pixel renderer and board RAM inside tt_um_vga_tetris.
- Display reads always win and have fixed latency; game port uses req/ack; clear sweeps the board on new game.

Parameters:
- COLS, 10, playfield columns
- ROWS, 20, playfield rows
- CELL_W, 3, bits per cell (colour index, 0 = empty)
- ADDR_W, 8, cell address width (row*COLS+col)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- disp_re  in  1  display read strobe
- disp_addr  in  ADDR_W  display cell address
- disp_rdata  out  CELL_W  display read data
- disp_rvalid  out  1  disp_rdata valid
- game_req  in  1  game transaction request, held until ack
- game_we  in  1  1 = write, 0 = read
- game_addr  in  ADDR_W  game cell address
- game_wdata  in  CELL_W  game write data
- game_ack  out  1  one-cycle completion pulse
- game_rdata  out  CELL_W  game read data, valid with game_ack
- clr_start  in  1  start board clear
- clr_busy  out  1  clear in progress
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  CELL_W  memory write data
- mem_rdata  in  CELL_W  memory read data, 1-cycle synchronous latency

Behaviour:
- Reset: state SERVE; all outputs 0; clear counter 0; game in-flight flag 0; pipeline valids 0.
- mem_* driven combinationally from the current-cycle arbitration decision; at most one access per cycle.
- Priority: display > clear (in CLEAR) > game (in SERVE).
- Display: disp_re in cycle t → mem read at t; disp_rdata/disp_rvalid registered, asserted exactly at t+2 for one cycle. Back-to-back reads every cycle supported; latency never varies.
- Game grant in cycle g when: state SERVE, disp_re=0, game_req=1, no game transaction in flight. Access performed at g. game_ack pulses at g+2; game_rdata = mem_rdata for reads, 0 for writes.
- In-flight flag set at g, cleared at g+2. Earliest next grant is g+3, so game_req held high is never double-granted.
- Game inputs must be stable from req until ack. Dropping req before ack is illegal and undefined.
- FSM SERVE → CLEAR when clr_start=1 in SERVE. clr_busy=1 from the next cycle.
- CLEAR: each cycle with disp_re=0, write 0 to address cnt, then cnt++. When the write at COLS*ROWS-1 is issued, reset cnt to 0 and return to SERVE; clr_busy drops the following cycle.
- clr_start while CLEAR: ignored.
- Game txn in flight when CLEAR begins: still acks on schedule.
- New game grants are blocked during CLEAR.
- Async rst mid-clear: aborts immediately. Board is left partially cleared; no restart.
- Simultaneous disp_re and game_req: display served, game waits, no ack.

Optional Feature:
- BOARD_ARB_BOUNDS_EN defined: any address ≥ COLS*ROWS is trapped.
  - Display: read suppressed (mem_en=0); disp_rvalid still at t+2 with data 0.
  - Game: access suppressed; ack still at g+2 with rdata 0.
  - Sticky output oob_err (1 bit, extra port) set; cleared only by rst.
- Undefined: addresses pass straight to memory; no oob_err port.

Decomposition:
- Shared package board_pkg:
  - COLS, ROWS, CELL_W, CELLS=COLS*ROWS
  - cell_t colour typedef with EMPTY=0
  - arb_state_t {SERVE, CLEAR}
- One natural sub-module, board_rd_pipe: 2-stage valid/tag pipeline tracking owner (disp/game/none) of each access so mem_rdata is routed at t+2. Instantiated once.

Test Plan:
- After rst, disp_re=1 addr=5 every cycle for 10 cycles with RAM[5]=3 → disp_rvalid high from cycle 2 onward, disp_rdata=3 every cycle, mem_we never 1.
- game_req write addr=12 data=6 with disp_re=0 → mem_we=1 at grant, game_ack exactly 2 cycles later, single pulse. Follow-up read addr=12 → game_rdata=6 with ack.
- game_req read held while disp_re=1 for 7 cycles → no game grant or ack during those cycles; grant on first disp_re=0 cycle, ack 2 cycles after it.
- clr_start with RAM filled with 7s, disp_re idle → clr_busy for 200 cycles, addresses 0..199 each written 0 once. Game req during clear acks only after clr_busy falls.
- clr_start, then disp_re every other cycle → clear takes 400 cycles. Display latency stays 2 throughout. Assert rst at cycle 50 of clear → clr_busy=0 immediately, no further mem_we.
- With BOARD_ARB_BOUNDS_EN: game write addr=200 → mem_en=0, ack at +2, oob_err=1 and stays 1 until rst.
